// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Control sequencer for an iterative, in-place radix-2 Cooley-Tukey FFT.
//   A transform starts with a start handshake. The sequencer then walks
//   every stage in turn. For each stage it issues SIZE_FFT/2 butterfly
//   commands to one shared butterfly unit, each as a valid/ready beat.
//   It waits for the datapath to drain before moving to the next stage.
//   After the last stage it raises done_val until the completion is
//   acknowledged.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   sine_wave_in        flattened sine table; entry m = sin(2*pi*m/N) at
//                       bits [m*BIT_WIDTH +: BIT_WIDTH]
//   start_val/start_rdy transform request handshake (ready only when idle)
//   bfly_val/bfly_rdy   butterfly command handshake
//   bfly_addr_a/b       upper/lower operand addresses
//   twiddle_real/imag   twiddle factor for the current butterfly
//   bfly_stage          current stage number
//   drain_done          datapath has written back the current stage
//   done_val/done_rdy   completion handshake
module fft_stage_sequencer #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int SIZE_FFT   = 8,
    parameter int LOG_N      = $clog2(SIZE_FFT)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [BIT_WIDTH*SIZE_FFT-1:0]  sine_wave_in,
    input  logic                           start_val,
    output logic                           start_rdy,
    output logic                           bfly_val,
    input  logic                           bfly_rdy,
    output logic [LOG_N-1:0]               bfly_addr_a,
    output logic [LOG_N-1:0]               bfly_addr_b,
    output logic [BIT_WIDTH-1:0]           twiddle_real,
    output logic [BIT_WIDTH-1:0]           twiddle_imaginary,
    output logic [$clog2(LOG_N):0]         bfly_stage,
    input  logic                           drain_done,
    output logic                           done_val,
    input  logic                           done_rdy
);

    localparam int SW = $clog2(LOG_N) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // SIZE_FFT/2-1 is all ones in the LOG_N-1 bit butterfly counter.
    localparam logic [LOG_N-2:0] BFLY_LAST  = '1;
    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG_N - 1);
    localparam logic [LOG_N-1:0] QUARTER    = LOG_N'(SIZE_FFT / 4);

    if ((SIZE_FFT < 4) || ((SIZE_FFT & (SIZE_FFT - 1)) != 0) ||
        (DECIMAL_PT >= BIT_WIDTH)) begin : g_param_check
        $error("fft_stage_sequencer: invalid parameterisation");
    end

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [LOG_N-2:0] bfly_q,  bfly_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        case (state_q)
            S_IDLE: begin
                if (start_val) begin
                    stage_d = '0;
                    bfly_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bfly_rdy) begin
                    if (bfly_q == BFLY_LAST) begin
                        bfly_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        bfly_d = bfly_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (done_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Butterfly geometry for stage s and index b:
    //   m = b mod 2^s, g = b >> s, a = g*2^(s+1) + m, b_addr = a + 2^s
    //   twiddle index idx = m << (LOG_N-1-s)
    logic [LOG_N-1:0]     b_ext, span, m_low, grp, addr_a, addr_b, tw_idx, re_idx;
    logic [SW-1:0]        tw_shift;
    logic [BIT_WIDTH-1:0] sin_re, sin_im;

    always_comb begin
        b_ext    = {1'b0, bfly_q};
        span     = LOG_N'(1) << stage_q;
        m_low    = b_ext & (span - 1'b1);
        grp      = b_ext >> stage_q;
        addr_a   = (grp << (stage_q + 1'b1)) | m_low;
        addr_b   = addr_a + span;
        tw_shift = STAGE_LAST - stage_q;
        tw_idx   = m_low << tw_shift;
        // cos(x) = sin(x + pi/2): quarter-table offset, wrapping mod N.
        re_idx   = tw_idx + QUARTER;
        sin_re   = sine_wave_in[32'(re_idx) * BIT_WIDTH +: BIT_WIDTH];
        sin_im   = sine_wave_in[32'(tw_idx) * BIT_WIDTH +: BIT_WIDTH];
    end

    logic issue;
    assign issue = (state_q == S_ISSUE);

    // Gated with reset_n so start_rdy drops the instant reset asserts.
    assign start_rdy         = reset_n && (state_q == S_IDLE);
    assign done_val          = (state_q == S_DONE);
    assign bfly_val          = issue;
    assign bfly_addr_a       = issue ? addr_a : '0;
    assign bfly_addr_b       = issue ? addr_b : '0;
    assign twiddle_real      = issue ? sin_re : '0;
    // Plain two's-complement negate: the most negative sample wraps to itself.
    assign twiddle_imaginary = issue ? ('0 - sin_im) : '0;
    assign bfly_stage        = issue ? stage_q : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;

    localparam int BW   = 8;
    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int SW   = $clog2(LOGN) + 1;

    logic                clk;
    logic                reset_n;
    logic [BW*N-1:0]     sine_wave_in;
    logic                start_val, start_rdy;
    logic                bfly_val, bfly_rdy;
    logic [LOGN-1:0]     bfly_addr_a, bfly_addr_b;
    logic [BW-1:0]       twiddle_real, twiddle_imaginary;
    logic [SW-1:0]       bfly_stage;
    logic                drain_done;
    logic                done_val, done_rdy;

    fft_stage_sequencer #(
        .BIT_WIDTH (BW),
        .DECIMAL_PT(4),
        .SIZE_FFT  (N)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sine_wave_in     (sine_wave_in),
        .start_val        (start_val),
        .start_rdy        (start_rdy),
        .bfly_val         (bfly_val),
        .bfly_rdy         (bfly_rdy),
        .bfly_addr_a      (bfly_addr_a),
        .bfly_addr_b      (bfly_addr_b),
        .twiddle_real     (twiddle_real),
        .twiddle_imaginary(twiddle_imaginary),
        .bfly_stage       (bfly_stage),
        .drain_done       (drain_done),
        .done_val         (done_val),
        .done_rdy         (done_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int a;
        int b;
        int re;
        int im;
        int st;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    hs_cyc   = 0;
    int    beat_cnt = 0;
    int    beat_base = 0;
    beat_t exp_q[$];
    beat_t log_q[$];
    int    log_off[$];

    // Hand-computed schedule for N=8 with sine_wave_in[j] = j.
    int lit_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_re [12] = '{2, 2, 2, 2, 2, 4, 2, 4, 2, 3, 4, 5};
    int lit_im [12] = '{0, 0, 0, 0, 0, 'hFE, 0, 'hFE, 0, 'hFF, 'hFE, 'hFD};
    int lit_off[12] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 13, 14};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sine_val(input int j);
        return j;
    endfunction

    // Textbook DIT schedule: stage s has butterfly span h = 2^s; butterfly b
    // lives in group b/h at offset b%h and uses W_N^k with k = (b%h)*N/(2h).
    function automatic void push_schedule();
        for (int s = 0; s < LOGN; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                beat_t e;
                int    h;
                int    k;
                h    = 1 << s;
                k    = (b % h) * (N / (2 * h));
                e.a  = (b / h) * 2 * h + (b % h);
                e.b  = e.a + h;
                e.re = sine_val((k + N / 4) % N);
                e.im = (256 - sine_val(k)) % 256;
                e.st = s;
                exp_q.push_back(e);
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Beat accounting: consume the model on every accepted command.
    always @(posedge clk) begin
        if (reset_n && bfly_val && bfly_rdy) begin
            beat_t c;
            c.a  = int'(bfly_addr_a);
            c.b  = int'(bfly_addr_b);
            c.re = int'(twiddle_real);
            c.im = int'(twiddle_imaginary);
            c.st = int'(bfly_stage);
            log_q.push_back(c);
            log_off.push_back(cyc - hs_cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            beat_cnt <= beat_cnt + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bfly_val) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("addr_a", bfly_addr_a, exp_q[0].a);
                    check("addr_b", bfly_addr_b, exp_q[0].b);
                    check("tw_re", twiddle_real, exp_q[0].re);
                    check("tw_im", twiddle_imaginary, exp_q[0].im);
                    check("stage", bfly_stage, exp_q[0].st);
                end
            end else begin
                check("cmd_zero_when_idle",
                      {bfly_addr_a, bfly_addr_b, twiddle_real, twiddle_imaginary, bfly_stage}, 0);
            end
            if (done_val) check("done_after_all_beats", exp_q.size(), 0);
        end
    end

    task automatic do_start();
        bit got;
        got = 1'b0;
        push_schedule();
        log_q.delete();
        log_off.delete();
        start_val = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            if (start_rdy) begin
                got       = 1'b1;
                hs_cyc    = cyc;
                beat_base = beat_cnt;
            end
        end
        check("start_handshake", got, 1);
        #1 start_val = 1'b0;
    endtask

    task automatic wait_done(output int off);
        bit got;
        got = 1'b0;
        off = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done_val) begin
                got = 1'b1;
                off = cyc - hs_cyc;
            end
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        int  off;
        bit  got;
        for (int j = 0; j < N; j++) sine_wave_in[j*BW +: BW] = BW'(j);
        reset_n    = 1'b1;
        start_val  = 1'b0;
        bfly_rdy   = 1'b1;
        drain_done = 1'b1;
        done_rdy   = 1'b0;

        // Reset then idle
        #2 reset_n = 1'b0;
        #1;
        check("rst_start_rdy", start_rdy, 0);
        check("rst_bfly_val", bfly_val, 0);
        check("rst_done_val", done_val, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("idle_start_rdy", start_rdy, 1);
        check("idle_outputs", {bfly_val, done_val, bfly_addr_a, bfly_addr_b,
                               twiddle_real, twiddle_imaginary, bfly_stage}, 0);

        // Full schedule, no stalls
        done_rdy = 1'b1;
        do_start();
        @(negedge clk);
        check("first_beat_latency", bfly_val, 1);
        wait_done(off);
        check("done_cycle", off, 16);
        check("beat_count", log_q.size(), 12);
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            check($sformatf("lit_a[%0d]", i), log_q[i].a, lit_a[i]);
            check($sformatf("lit_b[%0d]", i), log_q[i].b, lit_b[i]);
            check($sformatf("lit_re[%0d]", i), log_q[i].re, lit_re[i]);
            check($sformatf("lit_im[%0d]", i), log_q[i].im, lit_im[i]);
            check($sformatf("beat_off[%0d]", i), log_off[i], lit_off[i]);
        end
        @(negedge clk);
        check("done_cleared", done_val, 0);
        check("start_rdy_back", start_rdy, 1);

        // Backpressure on stage 1 beat 1
        do_start();
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bfly_val && bfly_stage == 1 && bfly_addr_a == 1) got = 1'b1;
        end
        check("bp_target_found", got, 1);
        bfly_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_val", bfly_val, 1);
            check("bp_hold", {bfly_addr_a, bfly_addr_b, twiddle_real, twiddle_imaginary},
                  {3'd1, 3'd3, 8'h04, 8'hFE});
            @(negedge clk);
        end
        bfly_rdy = 1'b1;
        check("bp_hold_last", {bfly_addr_a, bfly_addr_b}, {3'd1, 3'd3});
        wait_done(off);
        check("bp_done_cycle", off, 19);
        check("bp_beats", beat_cnt - beat_base, 12);
        @(negedge clk);

        // Drain stall after stage 0
        drain_done = 1'b0;
        do_start();
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (beat_cnt - beat_base == 4) got = 1'b1;
        end
        check("drain_reached", got, 1);
        for (int i = 0; i < 5; i++) begin
            check("drain_val_low", bfly_val, 0);
            check("drain_stage_zero", bfly_stage, 0);
            @(negedge clk);
        end
        drain_done = 1'b1;
        @(negedge clk);
        check("drain_resume", {bfly_val, bfly_stage, bfly_addr_a, bfly_addr_b},
              {1'b1, 3'd1, 3'd0, 3'd2});
        wait_done(off);
        check("drain_done_cycle", off, 21);
        @(negedge clk);

        // Done handshake with start_val held, then back-to-back
        done_rdy = 1'b0;
        do_start();
        wait_done(off);
        check("hs_done_cycle", off, 16);
        start_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("done_held", done_val, 1);
            check("start_ignored", {start_rdy, bfly_val}, 0);
            @(negedge clk);
        end
        done_rdy = 1'b1;
        @(negedge clk);
        check("done_ack", done_val, 0);
        check("start_rdy_after_ack", start_rdy, 1);
        do_start();
        @(negedge clk);
        check("b2b_first", {bfly_val, bfly_stage, bfly_addr_a, bfly_addr_b},
              {1'b1, 3'd0, 3'd0, 3'd1});
        wait_done(off);
        check("b2b_done_cycle", off, 16);
        @(negedge clk);

        // Abort during stage 1
        do_start();
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bfly_val && bfly_stage == 1) got = 1'b1;
        end
        check("abort_target_found", got, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_cleared", {start_rdy, bfly_val, done_val, bfly_addr_a, bfly_addr_b,
                                twiddle_real, twiddle_imaginary, bfly_stage}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", done_val, 0);
        check("abort_idle", start_rdy, 1);
        do_start();
        wait_done(off);
        check("abort_restart_done_cycle", off, 16);
        check("abort_restart_beats", log_q.size(), 12);
        if (log_q.size() > 0) check("abort_restart_first", {log_q[0].a, log_q[0].st}, {32'd0, 32'd0});
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Iterative (in-place) radix-2 Cooley-Tukey FFT controller.
- After a start handshake it walks all log2(SIZE_FFT) stages and issues one butterfly per accepted beat to a single shared butterfly unit. Each beat carries the operand pair addresses and the selected twiddle factor.
- Twiddles are indexed from the shared sine table (sine_wave_in[m] = sin(2*pi*m/N)), using the same stage/twiddle mapping as the parallel FFT.
- It waits for the datapath to drain between stages, then reports completion.

Parameters:
- BIT_WIDTH, 32, width of each sine sample and each twiddle component.
- DECIMAL_PT, 16, fixed-point position. Informational only; no arithmetic depends on it.
- SIZE_FFT, 8, transform size. Must be a power of two, >= 4.
- LOG_N, $clog2(SIZE_FFT), derived; do not override.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- sine_wave_in  in  BIT_WIDTH*SIZE_FFT  flattened sine table; entry m occupies bits [m*BIT_WIDTH +: BIT_WIDTH]. Held static during a transform.
- start_val  in  1  transform request.
- start_rdy  out  1  sequencer idle and able to accept.
- bfly_val  out  1  butterfly command valid.
- bfly_rdy  in  1  butterfly unit accepts the command.
- bfly_addr_a  out  LOG_N  upper operand address.
- bfly_addr_b  out  LOG_N  lower operand address.
- twiddle_real  out  BIT_WIDTH  twiddle real part.
- twiddle_imaginary  out  BIT_WIDTH  twiddle imaginary part.
- bfly_stage  out  $clog2(LOG_N)+1  current stage number.
- drain_done  in  1  datapath has written back every accepted butterfly of the current stage.
- done_val  out  1  transform complete.
- done_rdy  in  1  completion acknowledged.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - Counters stage=0 and bfly=0.
  - All outputs are 0, except start_rdy=1 once in IDLE.
  - Reset mid-transform abandons the transform immediately; no done_val is produced.
- States and transitions:
  - IDLE: start_rdy=1. On start_val&start_rdy, clear stage and bfly, then go to ISSUE.
  - ISSUE: bfly_val=1.
    - On a beat (bfly_val&bfly_rdy) with bfly < SIZE_FFT/2-1: increment bfly.
    - On a beat with bfly == SIZE_FFT/2-1: clear bfly and go to DRAIN.
    - While bfly_rdy=0: all command outputs hold stable and bfly_val stays high.
  - DRAIN: bfly_val=0. Wait for drain_done=1.
    - If stage < LOG_N-1: increment stage, go to ISSUE.
    - Otherwise go to DONE.
    - drain_done is ignored in every other state.
  - DONE: done_val=1 until done_rdy, then go to IDLE.
  - start_val is ignored outside IDLE.
- Command fields for stage s and butterfly index b (0..SIZE_FFT/2-1), combinationally derived from the registered state/counters:
  - m = b mod 2^s
  - g = b >> s
  - bfly_addr_a = g*2^(s+1) + m
  - bfly_addr_b = bfly_addr_a + 2^s
  - idx = m << (LOG_N-1-s), always < SIZE_FFT/2
  - twiddle_real = sine_wave_in[(idx + SIZE_FFT/4) mod SIZE_FFT]
  - twiddle_imaginary = two's-complement negation of sine_wave_in[idx], truncated to BIT_WIDTH
  - Negating the most-negative value wraps to itself; no saturation.
  - bfly_stage = s.
  - Command outputs are 0 when not in ISSUE.
- Timing:
  - First bfly_val is asserted the cycle after the start handshake.
  - With bfly_rdy held high, one beat per cycle: SIZE_FFT/2 consecutive beats per stage.
  - drain_done high on DRAIN entry gives a one-cycle bubble between stages.
  - done_val is asserted the cycle after the final DRAIN exit.
  - Minimum transform length = LOG_N*(SIZE_FFT/2 + 1) + 1 cycles from start handshake to done_val.
  - Back-to-back transforms: start_rdy returns the cycle after the done handshake.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> immediately start_rdy=0, bfly_val=0, done_val=0; after release start_rdy=1, all other outputs 0.
- Full N=8 schedule (BIT_WIDTH=8, sine_wave_in[j]=j, bfly_rdy=1, drain_done=1) -> (a,b,tw_re,tw_im) per beat:
  - Stage 0: (0,1,2,0), (2,3,2,0), (4,5,2,0), (6,7,2,0).
  - Stage 1: (0,2,2,0), (1,3,4,FE), (4,6,2,0), (5,7,4,FE).
  - Stage 2: (0,4,2,0), (1,5,3,FF), (2,6,4,FE), (3,7,5,FD).
  - done_val at cycle 16 after the start handshake.
- Backpressure: bfly_rdy=0 for 3 cycles on stage 1 beat 1 -> addr_a=1, addr_b=3, twiddle_real=4, twiddle_imaginary=FE held; no beat is skipped or duplicated; total of 12 beats.
- Drain stall: drain_done=0 for 5 cycles after stage 0 -> bfly_val=0 and bfly_stage outputs 0 throughout; stage 1 beat 0 is issued the cycle after drain_done rises.
- Done handshake and back-to-back: done_rdy=0 for 4 cycles -> done_val held, start_val ignored; done_rdy=1 then start_val=1 -> a new transform starts with stage 0 beat (0,1).
- Abort: reset_n pulsed low during stage 1 -> outputs cleared asynchronously; a new start yields a full 12-beat schedule from stage 0.
